// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered 32-bit ALU stage with carry/zero/sign flags
// Optional overflow flag output enabled by defining ALU_OVERFLOW_FLAG_EN.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             alu_sel,
  input  logic [4:0]       alu_op,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic             overflow,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign
);

  logic [WIDTH-1:0]   op_a, op_b, sum, shl, shr_l, shr_a, shift_res, next_result;
  logic [SHAMT_W-1:0] shamt;
  logic               cout, carry_upd, is_add;

  logic [WIDTH-1:0]   result_d, result_q;
  logic               carry_d, carry_q, zero_d, zero_q, sign_d, sign_q;
  logic               out_valid_d, out_valid_q;

  // alu_sel swaps in (1, ~b) so the adder produces -b without a separate negator.
  always_comb begin
    op_a        = alu_sel ? WIDTH'(1) : a;
    op_b        = alu_sel ? ~b : b;
    {cout, sum} = {1'b0, op_a} + {1'b0, op_b};
    shamt       = op_b[SHAMT_W-1:0];
    shl         = op_a << shamt;
    shr_l       = op_a >> shamt;
    shr_a       = $signed(op_a) >>> shamt;
    shift_res   = alu_op[1] ? (alu_op[0] ? shr_a : shr_l) : shl;
  end

  always_comb begin
    next_result = '0;
    carry_upd   = 1'b0;
    is_add      = 1'b0;
    case (alu_op)
      5'b00000: next_result = op_a;
      5'b00001: begin
        next_result = sum;
        carry_upd   = 1'b1;
        is_add      = 1'b1;
      end
      5'b00101, 5'b10101: begin
        next_result = sum;
        is_add      = 1'b1;
      end
      5'b00010: next_result = op_a & op_b;
      5'b00011: next_result = op_a ^ op_b;
      5'b01000, 5'b01001, 5'b01010, 5'b01011: next_result = shift_res;
      default:  next_result = '0;
    endcase
  end

  always_comb begin
    out_valid_d = in_valid;
    result_d    = in_valid ? next_result : result_q;
    zero_d      = in_valid ? (next_result == '0) : zero_q;
    sign_d      = in_valid ? next_result[WIDTH-1] : sign_q;
    carry_d     = (in_valid && carry_upd) ? cout : carry_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign sign      = sign_q;
  assign out_valid = out_valid_q;

`ifdef ALU_OVERFLOW_FLAG_EN
  logic overflow_d, overflow_q;

  always_comb begin
    overflow_d = overflow_q;
    if (in_valid)
      overflow_d = is_add && (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
// Overflow checks are compiled in when ALU_OVERFLOW_FLAG_EN is defined.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b;
  logic        alu_sel;
  logic [4:0]  alu_op;
  logic        out_valid, carry, zero, sign;
  logic [31:0] result;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .alu_op    (alu_op),
`ifdef ALU_OVERFLOW_FLAG_EN
    .overflow  (overflow),
`endif
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .sign      (sign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isel,
                       input logic [4:0] iop);
    a        = ia;
    b        = ib;
    alu_sel  = isel;
    alu_op   = iop;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] r, input logic c,
                           input logic z, input logic s, input logic v);
    check({tag, ".result"}, result, r);
    check({tag, ".carry"}, {31'd0, carry}, {31'd0, c});
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
    check({tag, ".sign"}, {31'd0, sign}, {31'd0, s});
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'd1; alu_sel = 1'b0; alu_op = 5'b00001;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    issue(32'hFFFFFFFF, 32'd1, 1'b0, 5'b00001);
    check_out("add_carry", 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(32'd2, 32'd3, 1'b0, 5'b00101);
    check_out("carry_hold", 32'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(32'd0, 32'd5, 1'b1, 5'b00101);
    check_out("negate", 32'hFFFFFFFB, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(32'd0, 32'd7, 1'b1, 5'b10101);
    check_out("negate_alt", 32'hFFFFFFF9, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(32'd1, 32'd1, 1'b0, 5'b00001);
    check_out("add_clr_carry", 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    issue(32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 5'b00010);
    check_out("and", 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 5'b00011);
    check_out("xor", 32'hFF00FF00, 1'b0, 1'b0, 1'b1, 1'b1);

    issue(32'h80000010, 32'd4, 1'b0, 5'b01000);
    check("sll", result, 32'h00000100);
    issue(32'h80000010, 32'd4, 1'b0, 5'b01001);
    check("sla", result, 32'h00000100);
    issue(32'h80000010, 32'd4, 1'b0, 5'b01010);
    check("srl", result, 32'h08000001);
    issue(32'h80000010, 32'd4, 1'b0, 5'b01011);
    check("sra", result, 32'hF8000001);
    check("sra.sign", {31'd0, sign}, 32'd1);
    issue(32'h80000010, 32'h00000020, 1'b0, 5'b01000);
    check("sll_shamt0", result, 32'h80000010);
    issue(32'h80000010, 32'h00000020, 1'b0, 5'b01011);
    check("sra_shamt0", result, 32'h80000010);
    issue(32'h00000001, 32'd31, 1'b0, 5'b01000);
    check("sll_31", result, 32'h80000000);

    issue(32'hFFFFFFFF, 32'd1, 1'b0, 5'b11111);
    check_out("undef_op", 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(32'hDEADBEEF, 32'd0, 1'b0, 5'b00000);
    check_out("pass_a", 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(32'hDEADBEEF, 32'd0, 1'b1, 5'b00000);
    check("pass_one", result, 32'd1);

    // Idle cycle: results and flags must hold while out_valid drops.
    in_valid = 1'b0; a = 32'h12345678; alu_op = 5'b00000;
    @(posedge clk); #1;
    check_out("idle_hold", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    issue(32'hFFFFFFFF, 32'd1, 1'b0, 5'b00001);
    check("carry_set_again", {31'd0, carry}, 32'd1);
    rst_n = 1'b0;
    issue(32'd3, 32'd4, 1'b0, 5'b00001);
    check_out("reset_priority", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

`ifdef ALU_OVERFLOW_FLAG_EN
    issue(32'h7FFFFFFF, 32'd1, 1'b0, 5'b00001);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    issue(32'h80000000, 32'h80000000, 1'b0, 5'b00101);
    check("ovf_neg", {31'd0, overflow}, 32'd1);
    issue(32'h7FFFFFFF, 32'd1, 1'b0, 5'b00011);
    check("ovf_nonadd", {31'd0, overflow}, 32'd0);
    issue(32'd1, 32'd1, 1'b0, 5'b00001);
    check("ovf_clear", {31'd0, overflow}, 32'd0);
`endif

    in_valid = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered 32-bit integer ALU stage for the single-cycle/multicycle CPU datapath.
- Composed internally of a 2:1 32-bit operand mux pair, a 32-bit ripple/CLA adder and a 32-bit barrel shifter.
- Computes pass, add, negate, AND, XOR and shifts, and registers the result with carry, zero and sign flags one cycle after issue.

Parameters:
- WIDTH, 32, datapath width; the only supported value is 32.
- SHAMT_W, 5, number of operand-B LSBs used as the shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands/opcode valid this cycle.
- a  input  32  operand A, signed.
- b  input  32  operand B, signed.
- alu_sel  input  1  0: operands (a, b); 1: operands (32'd1, ~b).
- alu_op  input  5  operation code.
- out_valid  output  1  result/flags valid.
- result  output  32  registered result.
- carry  output  1  registered adder carry-out, sticky between carry-updating ops.
- zero  output  1  registered, 1 when result == 0.
- sign  output  1  registered result[31].

Behaviour:
- Reset is synchronous and active-low: on a clk edge with rst_n=0, result, carry, zero, sign and out_valid are all cleared to 0.
- Operand select, combinational:
  - opA = alu_sel ? 32'd1 : a.
  - opB = alu_sel ? ~b : b.
- Adder: {cout, sum} = opA + opB, with carry-in 0. With alu_sel=1 this yields -b in two's complement.
- Shifter: input opA, shamt = opB[4:0].
  - dir = alu_op[1]: 0 shifts left, 1 shifts right.
  - aorl = alu_op[0]: 1 is arithmetic, 0 is logical.
  - Left arithmetic is identical to left logical.
  - shamt 0 returns opA unchanged.
- Opcode decode (next_result):
  - 00000: opA (pass/load-1).
  - 00001: sum; carry register also updated with cout.
  - 00101, 10101: sum; carry register holds its value.
  - 00010: opA & opB.
  - 00011: opA ^ opB.
  - 01000: shift left logical.
  - 01001: shift left, same result as 01000.
  - 01010: shift right logical.
  - 01011: shift right arithmetic, sign-filling.
  - All other codes: 32'd0, with carry held.
- Latency: when in_valid=1, on the next rising edge:
  - result <= next_result.
  - zero <= (next_result == 0).
  - sign <= next_result[31].
  - out_valid <= 1.
- When in_valid=0: out_valid <= 0, and result/flags hold their values.
- There is no backpressure. A new operation may issue every cycle; back-to-back ops give back-to-back results.
- Arithmetic wraps modulo 2^32. carry is the unsigned carry-out.
- Reset asserted during a valid issue takes priority: all outputs are 0 on the next cycle.

Optional Feature:
- Macro ALU_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port overflow (1 bit, registered).
  - On add opcodes 00001, 00101 and 10101, overflow <= (opA[31]==opB[31]) && (sum[31]!=opA[31]).
  - On other opcodes overflow <= 0.
  - overflow resets to 0.
- When undefined: the port and its logic are absent; everything else is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> result=0, carry=0, zero=0, sign=0, out_valid=0.
- Add with carry: a=32'hFFFFFFFF, b=1, alu_sel=0, op=00001 -> one cycle later result=0, carry=1, zero=1, sign=0.
- Carry hold: then a=2, b=3, op=00101 -> result=5, carry remains 1.
- Negate: b=5, alu_sel=1, op=00101 -> result=32'hFFFFFFFB, sign=1, zero=0.
- Logic:
  - a=32'hF0F0F0F0, b=32'h0FF00FF0, op=00010 -> result=32'h00F000F0.
  - Same operands, op=00011 -> result=32'hFF00FF00.
- Shifts with a=32'h80000010, b=4:
  - op=01000 -> 32'h00000100.
  - op=01010 -> 32'h08000001.
  - op=01011 -> 32'hF8000001.
- Shift edge: b=32'h00000020 (shamt=0), op=01000 -> result=a.
- Undefined opcode 11111 -> result=0, zero=1.
- Overflow (with ALU_OVERFLOW_FLAG_EN): a=32'h7FFFFFFF, b=1, op=00001 -> overflow=1.
